// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_RD     = 2;

    function automatic int rf_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, issuing one zero-write per cycle.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

    rf_state_e             state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  busy_r;

    // Clear FSM with counter; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RF_IDLE;
            cnt_r   <= ADDR_ZERO;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                RF_IDLE: begin
                    if (clr_i) begin
                        state_r <= RF_CLEAR;
                        cnt_r   <= ADDR_ZERO;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= RF_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    cnt_r <= cnt_r + ADDR_ONE;
                    if (cnt_r == ADDR_LAST) begin
                        state_r <= RF_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= RF_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= RF_IDLE;
                    cnt_r   <= ADDR_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign clr_we_o   = busy_r;
    assign clr_addr_o = cnt_r;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte strobes, optional zero entry and bulk clear.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int ZERO_REG   = 1
)
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we_i,
    input  logic [ADDR_WIDTH-1:0]            wa_i,
    input  logic [DATA_WIDTH-1:0]            wd_i,
    input  logic [rf_bytes(DATA_WIDTH)-1:0]  wstrb_i,
    input  logic [NUM_RD-1:0]                re_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     ra_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]     rd_o,
    output logic [NUM_RD-1:0]                rvalid_o,
    input  logic                             clr_i,
    output logic                             busy_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = rf_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  busy_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] merged_s;

    rf_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .busy_o     (busy_s),
        .clr_we_o   (clr_we_s),
        .clr_addr_o (clr_addr_s)
    );

    assign busy_o = busy_s;

    // A clear request in the same cycle wins over a user write.
    assign wr_en_s = we_i && !busy_s && !clr_i && (|wstrb_i)
                     && !((ZERO_REG != 0) && (wa_i == ADDR_ZERO));

    // Strobe merge of incoming bytes over the currently stored word.
    always_comb begin
        merged_s = mem_r[wa_i];
        for (int k = 0; k < NB; k++) begin
            if (wstrb_i[k]) begin
                merged_s[8*k +: 8] = wd_i[8*k +: 8];
            end else begin
                merged_s[8*k +: 8] = mem_r[wa_i][8*k +: 8];
            end
        end
    end

    // Storage update; reset suppresses the in-flight clear write so an abort leaves the rest intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r <= mem_r;
        end else if (clr_we_s) begin
            mem_r[clr_addr_s] <= DATA_ZERO;
        end else if (wr_en_s) begin
            mem_r[wa_i] <= merged_s;
        end else begin
            mem_r <= mem_r;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rdata_s;
        logic [DATA_WIDTH-1:0] rd_r;
        logic                  rvalid_r;

        assign ra_s = ra_i[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Read-data select: zero entry first, then optional forwarding, else storage.
        always_comb begin
            if ((ZERO_REG != 0) && (ra_s == ADDR_ZERO)) begin
                rdata_s = DATA_ZERO;
`ifdef RF_BYPASS_EN
            end else if (wr_en_s && (wa_i == ra_s)) begin
                rdata_s = merged_s;
`endif
            end else begin
                rdata_s = mem_r[ra_s];
            end
        end

        // Registered read port; data holds when no read is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_r     <= DATA_ZERO;
                rvalid_r <= 1'b0;
            end else if (re_i[p] && !busy_s) begin
                rd_r     <= rdata_s;
                rvalid_r <= 1'b1;
            end else begin
                rd_r     <= rd_r;
                rvalid_r <= 1'b0;
            end
        end

        assign rd_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_r;
        assign rvalid_o[p]                      = rvalid_r;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file, the next generation of the team's single-port `REG_FILE`: one write port with byte strobes, `NUM_RD` independent registered read ports, an optional hardwired-zero entry, and a sequenced bulk-clear engine. It sits beside the TPU datapath as the operand/configuration store, feeding several consumers per cycle.

## Interface
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5, address width; depth is `DEPTH = 2**ADDR_WIDTH`.
- `NUM_RD`, 2, number of read ports, 1..4.
- `ZERO_REG`, 1, when 1 entry 0 reads as zero and ignores writes.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `we_i`  in  1  write enable.
- `wa_i`  in  ADDR_WIDTH  write address.
- `wd_i`  in  DATA_WIDTH  write data.
- `wstrb_i`  in  DATA_WIDTH/8  byte write strobes; bit k enables `wd_i[8k+7:8k]`.
- `re_i`  in  NUM_RD  per-port read enable.
- `ra_i`  in  NUM_RD*ADDR_WIDTH  read addresses; port p at `[p*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rd_o`  out  NUM_RD*DATA_WIDTH  registered read data; port p at `[p*DATA_WIDTH +: DATA_WIDTH]`.
- `rvalid_o`  out  NUM_RD  per-port read-data valid.
- `clr_i`  in  1  start bulk clear (single-cycle pulse or level).
- `busy_o`  out  1  clear in progress.

## Operation
- Write: at a rising edge with `we_i=1` and not busy, bytes of entry `wa_i` with `wstrb_i[k]=1` take `wd_i`; other bytes hold. `wstrb_i=0` is a no-op.
- `ZERO_REG=1`: writes to address 0 discarded; reads of address 0 return 0.
- Read: port p with `re_i[p]=1` and not busy samples entry `ra_i[p]`; result registered onto `rd_o[p]`, `rvalid_o[p]=1` next cycle. With `re_i[p]=0`, `rvalid_o[p]=0` and `rd_o[p]` holds its last value.
- Several ports may read the same address in the same cycle; all get identical data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: `clr_i=1` -> CLEAR, counter=0.
  - CLEAR: zero entry `counter`, increment; after entry DEPTH-1 -> IDLE. `clr_i` ignored.
  - `busy_o=1` exactly in CLEAR.
- While busy: `we_i`, `re_i` ignored; `rvalid_o=0`.
- `clr_i` and `we_i` in the same IDLE cycle: clear wins, write dropped. `clr_i` and `re_i` in the same cycle: read is served (returns pre-clear data).
- Reset: FSM IDLE, counter 0, `busy_o=0`, `rvalid_o=0`, `rd_o=0`. Storage array is not reset; reset during CLEAR aborts the clear, leaving entries above the counter unchanged.

## Timing
- Write at edge N is visible to reads sampled at edge N+1 (`rd_o` at N+1 after the edge).
- Read latency 1 cycle: `re_i` sampled at edge N -> `rd_o`/`rvalid_o` valid after edge N.
- Clear: `clr_i` sampled at edge N -> `busy_o` high from N to N+DEPTH, low after edge N+DEPTH; first access accepted at edge N+DEPTH+1.
- Same-cycle write/read to the same address: see Configuration.

## Configuration
- `RF_BYPASS_EN` defined: a read sampled at the same edge as a write to the same address returns the strobe-merged new word (old bytes where strobe=0, `wd_i` bytes where strobe=1). Address 0 with `ZERO_REG=1` still returns 0.
- Not defined: such a read returns the old stored word; new data is visible one cycle later. No forwarding mux is generated.

## Structure
- Package `rf_pkg`: clear FSM state enum (`RF_IDLE`, `RF_CLEAR`), default width constants, byte-count helper `DATA_WIDTH/8`.
- Sub-module `rf_clear_seq`: FSM plus address counter; outputs `busy_o`, clear-write enable, clear address. Storage, strobe merge, read ports and bypass stay in `reg_file_mp`.

## Test plan
- Write 0x11111111..0x44444444 to addresses 1..4 with strobe 0xF, then read 1 on port 0 and 2 on port 1 -> next cycle `rd_o` = 0x11111111 / 0x22222222, `rvalid_o`=2'b11.
- Write 0xAABBCCDD to address 5, then 0x00000099 with strobe 4'b0001 -> read returns 0xAABBCC99.
- Write 0xFFFFFFFF to address 0 (`ZERO_REG=1`) -> read returns 0; both ports reading address 3 simultaneously -> identical data.
- Write 0x12345678 to address 7 and read address 7 at the same edge -> 0x12345678 with `RF_BYPASS_EN`, previous value without.
- Pulse `clr_i` with `we_i` to address 9 in the same cycle -> `busy_o` high exactly 32 cycles, reads ignored meanwhile, afterwards all entries read 0 (address 9 not written).
- Assert `rst` 10 cycles into a clear -> `busy_o`=0, `rvalid_o`=0 next cycle; entries 0..9 read 0, entry 20 retains its pre-clear value.
